// File: rtl/ntt_sdf_ctrl.sv
// Per-stage control for an SDF NTT/INTT butterfly stage: fifo1 addressing,
// butterfly/feedback select, twiddle index and output-beat valid/last tracking.
module ntt_sdf_ctrl #(
  parameter int unsigned LOG_N   = 8,
  parameter int unsigned K       = 0,
  parameter int unsigned TW_BASE = 1,
  parameter int unsigned LAT     = 1,
  localparam int unsigned AW     = (K > 0) ? K : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [AW-1:0]    fifo1_addr,
  output logic             sel,
  output logic [LOG_N-1:0] tw_idx,
  output logic             out_valid,
  output logic             out_last
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } mode_t;

  localparam logic [LOG_N-1:0] CNT_ONE  = LOG_N'(1);
  localparam logic [LOG_N-1:0] TAIL_END = LOG_N'((1 << K) - 1);
  localparam logic [LOG_N-1:0] TW_B     = LOG_N'(TW_BASE);

  mode_t            r_mode, w_mode_nxt;
  logic [LOG_N-1:0] r_cnt, w_cnt_nxt;
  logic             r_pend, w_pend_nxt;
  logic             w_adv;
  logic             w_sel;
  logic             w_beat_valid;
  logic             w_beat_last;

  assign w_sel    = r_cnt[K];
  assign in_ready = (r_mode != DRAIN);
  assign wr_en    = w_adv;
  assign sel      = w_sel;
  assign tw_idx   = TW_B + (r_cnt >> (K + 1));

  generate
    if (K == 0) begin : g_addr_k0
      assign fifo1_addr = '0;
    end else begin : g_addr
      assign fifo1_addr = r_cnt[AW-1:0];
    end
  endgenerate

  always_comb begin
    w_adv        = (in_valid && in_ready) || (r_mode == DRAIN);
    w_beat_valid = w_adv && (w_sel || r_pend);
    // pend marks feedback data still sitting in fifo1; its last word leaves at cnt==D-1
    w_beat_last  = w_adv && r_pend && (r_cnt == TAIL_END);

    w_mode_nxt = r_mode;
    w_cnt_nxt  = r_cnt;
    w_pend_nxt = r_pend;

    if (w_adv) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
      if (w_sel) begin
        w_pend_nxt = 1'b1;
      end
    end

    unique case (r_mode)
      EMPTY: begin
        if (w_adv) begin
          w_mode_nxt = STREAM;
        end
      end
      STREAM: begin
        if ((r_cnt == '0) && r_pend && !in_valid) begin
          w_mode_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_cnt == TAIL_END) begin
          w_mode_nxt = EMPTY;
          w_cnt_nxt  = '0;
          w_pend_nxt = 1'b0;
        end
      end
      default: begin
        w_mode_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= EMPTY;
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  generate
    if (LAT == 0) begin : g_lat0
      assign out_valid = w_beat_valid;
      assign out_last  = w_beat_last;
    end else begin : g_lat
      logic [LAT-1:0] r_vpipe;
      logic [LAT-1:0] r_lpipe;

      // Free-running shift: stalls become bubbles rather than holding beats
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vpipe <= '0;
          r_lpipe <= '0;
        end else begin
          r_vpipe <= LAT'({r_vpipe, w_beat_valid});
          r_lpipe <= LAT'({r_lpipe, w_beat_last});
        end
      end

      assign out_valid = r_vpipe[LAT-1];
      assign out_last  = r_lpipe[LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_ntt_sdf_ctrl.sv
// Self-checking bench for ntt_sdf_ctrl: three instances (K=1, K=0, K=LOG_N-1)
// driven from cycle tables; output beats checked through a per-instance scoreboard queue.
module tb_ntt_sdf_ctrl;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT2 = 1;

  typedef struct {
    bit v;
    int cnt;
    bit rdy;
    bit bv;
    bit bl;
  } row_t;

  logic clk;
  logic rst;

  logic       in_valid1, in_ready1, wr_en1, sel1, out_valid1, out_last1;
  logic [0:0] fifo1_addr1;
  logic [2:0] tw_idx1;

  logic       in_valid0, in_ready0, wr_en0, sel0, out_valid0, out_last0;
  logic [0:0] fifo1_addr0;
  logic [2:0] tw_idx0;

  logic       in_valid2, in_ready2, wr_en2, sel2, out_valid2, out_last2;
  logic [1:0] fifo1_addr2;
  logic [2:0] tw_idx2;

  logic [1:0] q1[$];
  logic [1:0] q0[$];
  logic [1:0] q2[$];

  int n_pass;
  int n_total;

  ntt_sdf_ctrl #(.LOG_N(3), .K(1), .TW_BASE(1), .LAT(LAT1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .wr_en(wr_en1),
    .fifo1_addr(fifo1_addr1), .sel(sel1), .tw_idx(tw_idx1),
    .out_valid(out_valid1), .out_last(out_last1)
  );

  ntt_sdf_ctrl #(.LOG_N(3), .K(0), .TW_BASE(2), .LAT(LAT0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .wr_en(wr_en0),
    .fifo1_addr(fifo1_addr0), .sel(sel0), .tw_idx(tw_idx0),
    .out_valid(out_valid0), .out_last(out_last0)
  );

  ntt_sdf_ctrl #(.LOG_N(3), .K(2), .TW_BASE(5), .LAT(LAT2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .wr_en(wr_en2),
    .fifo1_addr(fifo1_addr2), .sel(sel2), .tw_idx(tw_idx2),
    .out_valid(out_valid2), .out_last(out_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input bit v, input int cnt, input bit rdy, input bit bv, input bit bl);
    row_t r;
    r.v   = v;
    r.cnt = cnt;
    r.rdy = rdy;
    r.bv  = bv;
    r.bl  = bl;
    return r;
  endfunction

  // Expected {in_ready, wr_en, sel, addr[1:0], tw_idx[2:0]} for a cycle at count r.cnt
  function automatic logic [7:0] exp_ctl(input int unsigned k, input int unsigned twb, input row_t r);
    logic [7:0]  e;
    int unsigned d;
    int unsigned c;
    d = 1 << k;
    c = int'(r.cnt);
    e[7]   = r.rdy;
    e[6]   = r.rdy ? r.v : 1'b1;
    e[5]   = ((c >> k) & 1) != 0;
    e[4:3] = 2'(c % d);
    e[2:0] = 3'((twb + (c >> (k + 1))) % 8);
    return e;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid1 = 1'b0;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    q1.delete();
    q0.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    do_reset();
    in_valid1 = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #2;
    end
    n_total++;
    if (out_valid1 !== 1'b1) $display("FAIL reset_prestream out_valid: got %b expected 1", out_valid1);
    else n_pass++;
    rst       = 1'b1;
    in_valid1 = 1'b0;
    #1;
    got = {in_ready1, sel1, fifo1_addr1, out_valid1, out_last1, tw_idx1};
    n_total++;
    if (got !== 8'b1000_0001) $display("FAIL reset_async rdy/sel/addr/ov/ol/tw: got %b expected 10000001", got);
    else n_pass++;
    @(posedge clk);
    #1;
    got = {in_ready1, sel1, fifo1_addr1, out_valid1, out_last1, tw_idx1};
    n_total++;
    if (got !== 8'b1000_0001) $display("FAIL reset_held rdy/sel/addr/ov/ol/tw: got %b expected 10000001", got);
    else n_pass++;
    rst = 1'b0;
    #1;
    got = {in_ready1, wr_en1, sel1, fifo1_addr1, out_valid1, tw_idx1};
    n_total++;
    if (got !== 8'b1000_0001) $display("FAIL reset_release rdy/wr/sel/addr/ov/tw: got %b expected 10000001", got);
    else n_pass++;
    in_valid1 = 1'b1;
    @(posedge clk);
    #2;
    in_valid1 = 1'b0;
    got = {5'b0, sel1, fifo1_addr1, out_valid1};
    n_total++;
    if (got !== 8'b0000_0010) $display("FAIL reset_first_beat sel/addr/ov: got %b expected 00000010", got);
    else n_pass++;
  endtask

  task automatic test_single();
    row_t       t[$];
    logic [7:0] e;
    logic [7:0] got;
    logic [1:0] o;
    int         nv = 0;
    int         nl = 0;
    do_reset();
    for (int c = 0; c < 8; c++) t.push_back(mk(1, c, 1, c >= 2, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 0));
    t.push_back(mk(0, 1, 0, 1, 1));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    foreach (t[i]) begin
      in_valid1 = t[i].v;
      #1;
      e   = exp_ctl(1, 1, t[i]);
      got = {in_ready1, wr_en1, sel1, 1'b0, fifo1_addr1, tw_idx1};
      n_total++;
      if (got !== e) $display("FAIL single ctl cyc%0d: got %b expected %b", i, got, e);
      else n_pass++;
      q1.push_back({t[i].bv, t[i].bl});
      @(negedge clk);
      if (q1.size() > LAT1) begin
        o = q1.pop_front();
        n_total++;
        if ({out_valid1, out_last1} !== o) $display("FAIL single out cyc%0d: got %b expected %b", i, {out_valid1, out_last1}, o);
        else n_pass++;
      end
      if (out_valid1) nv++;
      if (out_last1) nl++;
      @(posedge clk);
      #2;
    end
    n_total++;
    if (nv != 8 || nl != 1) $display("FAIL single totals valid/last: got %0d/%0d expected 8/1", nv, nl);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    row_t       t[$];
    logic [7:0] e;
    logic [7:0] got;
    logic [1:0] o;
    int         nv = 0;
    int         nl = 0;
    do_reset();
    for (int c = 0; c < 16; c++) t.push_back(mk(1, c % 8, 1, c >= 2, c == 9));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 0));
    t.push_back(mk(0, 1, 0, 1, 1));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    foreach (t[i]) begin
      in_valid1 = t[i].v;
      #1;
      e   = exp_ctl(1, 1, t[i]);
      got = {in_ready1, wr_en1, sel1, 1'b0, fifo1_addr1, tw_idx1};
      n_total++;
      if (got !== e) $display("FAIL b2b ctl cyc%0d: got %b expected %b", i, got, e);
      else n_pass++;
      q1.push_back({t[i].bv, t[i].bl});
      @(negedge clk);
      if (q1.size() > LAT1) begin
        o = q1.pop_front();
        n_total++;
        if ({out_valid1, out_last1} !== o) $display("FAIL b2b out cyc%0d: got %b expected %b", i, {out_valid1, out_last1}, o);
        else n_pass++;
      end
      if (out_valid1) nv++;
      if (out_last1) nl++;
      @(posedge clk);
      #2;
    end
    n_total++;
    if (nv != 16 || nl != 2) $display("FAIL b2b totals valid/last: got %0d/%0d expected 16/2", nv, nl);
    else n_pass++;
  endtask

  task automatic test_stall();
    row_t       t[$];
    logic [7:0] e;
    logic [7:0] got;
    logic [1:0] o;
    int         nv = 0;
    do_reset();
    for (int c = 0; c < 5; c++) t.push_back(mk(1, c, 1, c >= 2, 0));
    for (int s = 0; s < 3; s++) t.push_back(mk(0, 5, 1, 0, 0));
    for (int c = 5; c < 8; c++) t.push_back(mk(1, c, 1, 1, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 0));
    t.push_back(mk(0, 1, 0, 1, 1));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    foreach (t[i]) begin
      in_valid1 = t[i].v;
      #1;
      e   = exp_ctl(1, 1, t[i]);
      got = {in_ready1, wr_en1, sel1, 1'b0, fifo1_addr1, tw_idx1};
      n_total++;
      if (got !== e) $display("FAIL stall ctl cyc%0d: got %b expected %b", i, got, e);
      else n_pass++;
      q1.push_back({t[i].bv, t[i].bl});
      @(negedge clk);
      if (q1.size() > LAT1) begin
        o = q1.pop_front();
        n_total++;
        if ({out_valid1, out_last1} !== o) $display("FAIL stall out cyc%0d: got %b expected %b", i, {out_valid1, out_last1}, o);
        else n_pass++;
      end
      if (out_valid1) nv++;
      @(posedge clk);
      #2;
    end
    n_total++;
    if (nv != 8) $display("FAIL stall total valid: got %0d expected 8", nv);
    else n_pass++;
  endtask

  task automatic test_drain_decision();
    row_t       t[$];
    logic [7:0] e;
    logic [7:0] got;
    logic [1:0] o;
    int         nv = 0;
    int         nl = 0;
    do_reset();
    for (int c = 0; c < 8; c++) t.push_back(mk(1, c, 1, c >= 2, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(1, 0, 0, 1, 0));
    t.push_back(mk(1, 1, 0, 1, 1));
    for (int c = 0; c < 8; c++) t.push_back(mk(1, c, 1, c >= 2, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 0));
    t.push_back(mk(0, 1, 0, 1, 1));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    foreach (t[i]) begin
      in_valid1 = t[i].v;
      #1;
      e   = exp_ctl(1, 1, t[i]);
      got = {in_ready1, wr_en1, sel1, 1'b0, fifo1_addr1, tw_idx1};
      n_total++;
      if (got !== e) $display("FAIL drain_dec ctl cyc%0d: got %b expected %b", i, got, e);
      else n_pass++;
      q1.push_back({t[i].bv, t[i].bl});
      @(negedge clk);
      if (q1.size() > LAT1) begin
        o = q1.pop_front();
        n_total++;
        if ({out_valid1, out_last1} !== o) $display("FAIL drain_dec out cyc%0d: got %b expected %b", i, {out_valid1, out_last1}, o);
        else n_pass++;
      end
      if (out_valid1) nv++;
      if (out_last1) nl++;
      @(posedge clk);
      #2;
    end
    n_total++;
    if (nv != 16 || nl != 2) $display("FAIL drain_dec totals valid/last: got %0d/%0d expected 16/2", nv, nl);
    else n_pass++;
  endtask

  task automatic test_k0();
    row_t       t[$];
    logic [7:0] e;
    logic [7:0] got;
    logic [1:0] o;
    int         nv = 0;
    int         nl = 0;
    do_reset();
    for (int c = 0; c < 8; c++) t.push_back(mk(1, c, 1, c >= 1, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 1));
    for (int s = 0; s < 3; s++) t.push_back(mk(0, 0, 1, 0, 0));
    foreach (t[i]) begin
      in_valid0 = t[i].v;
      #1;
      e   = exp_ctl(0, 2, t[i]);
      got = {in_ready0, wr_en0, sel0, 1'b0, fifo1_addr0, tw_idx0};
      n_total++;
      if (got !== e) $display("FAIL k0 ctl cyc%0d: got %b expected %b", i, got, e);
      else n_pass++;
      q0.push_back({t[i].bv, t[i].bl});
      @(negedge clk);
      if (q0.size() > LAT0) begin
        o = q0.pop_front();
        n_total++;
        if ({out_valid0, out_last0} !== o) $display("FAIL k0 out cyc%0d: got %b expected %b", i, {out_valid0, out_last0}, o);
        else n_pass++;
      end
      if (out_valid0) nv++;
      if (out_last0) nl++;
      @(posedge clk);
      #2;
    end
    n_total++;
    if (nv != 8 || nl != 1) $display("FAIL k0 totals valid/last: got %0d/%0d expected 8/1", nv, nl);
    else n_pass++;
  endtask

  task automatic test_kmax();
    row_t       t[$];
    logic [7:0] e;
    logic [7:0] got;
    logic [1:0] o;
    int         nv = 0;
    int         nl = 0;
    do_reset();
    for (int c = 0; c < 8; c++) t.push_back(mk(1, c, 1, c >= 4, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    for (int c = 0; c < 4; c++) t.push_back(mk(0, c, 0, 1, c == 3));
    t.push_back(mk(0, 0, 1, 0, 0));
    t.push_back(mk(0, 0, 1, 0, 0));
    foreach (t[i]) begin
      in_valid2 = t[i].v;
      #1;
      e   = exp_ctl(2, 5, t[i]);
      got = {in_ready2, wr_en2, sel2, fifo1_addr2, tw_idx2};
      n_total++;
      if (got !== e) $display("FAIL kmax ctl cyc%0d: got %b expected %b", i, got, e);
      else n_pass++;
      q2.push_back({t[i].bv, t[i].bl});
      @(negedge clk);
      if (q2.size() > LAT2) begin
        o = q2.pop_front();
        n_total++;
        if ({out_valid2, out_last2} !== o) $display("FAIL kmax out cyc%0d: got %b expected %b", i, {out_valid2, out_last2}, o);
        else n_pass++;
      end
      if (out_valid2) nv++;
      if (out_last2) nl++;
      @(posedge clk);
      #2;
    end
    n_total++;
    if (nv != 8 || nl != 1) $display("FAIL kmax totals valid/last: got %0d/%0d expected 8/1", nv, nl);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_valid1 = 1'b0;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_drain_decision();
    test_k0();
    test_kmax();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
